// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types for the load/store unit: access size, response
//               error code, control FSM state, and the alignment check.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_SIZE     = 2'd3
    } err_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // Natural alignment: the low log2(size-in-bytes) address bits must be zero.
    function automatic logic is_misaligned(input size_e size, input logic [2:0] lo);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = lo[0];
            SZ_W:    bad = |lo[1:0];
            default: bad = |lo[2:0];
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Byte-lane alignment. Builds the store byte mask and the
//               lane-shifted store data, and extracts/extends load data from
//               a full aligned memory word.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int IW   = $clog2(XLEN / 8)
) (
    input  size_e               size,
    input  logic                is_unsigned,
    input  logic [IW-1:0]       idx,
    input  logic [XLEN-1:0]     wdata,
    input  logic [XLEN-1:0]     rdata,
    output logic [XLEN/8-1:0]   wmask,
    output logic [XLEN-1:0]     wdata_sh,
    output logic [XLEN-1:0]     rdata_ext
);

    logic [XLEN/8-1:0] w_base;
    logic [XLEN-1:0]   w_keep;
    logic [XLEN-1:0]   w_shr;
    logic              w_sign;

    // Size-dependent lane mask, kept-bit mask and sign bit; a double keeps all bits unextended.
    always_comb begin
        w_base = '0;
        w_keep = '0;
        w_shr  = rdata >> {idx, 3'b000};
        w_sign = 1'b0;
        case (size)
            SZ_B: begin
                w_base[0]    = 1'b1;
                w_keep[7:0]  = '1;
                w_sign       = w_shr[7];
            end
            SZ_H: begin
                w_base[1:0]  = '1;
                w_keep[15:0] = '1;
                w_sign       = w_shr[15];
            end
            SZ_W: begin
                w_base[3:0]  = '1;
                w_keep[31:0] = '1;
                w_sign       = w_shr[31];
            end
            default: begin
                w_base = '1;
                w_keep = '1;
                w_sign = 1'b0;
            end
        endcase
        wmask     = w_base << idx;
        wdata_sh  = wdata << {idx, 3'b000};
        rdata_ext = (w_shr & w_keep) | ((w_sign && !is_unsigned) ? ~w_keep : '0);
    end

endmodule
`default_nettype wire

// File: rtl/lsu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pipe
// Description : Handshaked load/store unit. Accepts one EXU request at a
//               time, checks size/alignment, issues it on a req/resp memory
//               port, and returns extended load data or an error code.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_pipe
    import lsu_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int AW      = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wen,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [AW-1:0]       req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic [1:0]          rsp_err,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [AW-1:0]       mem_addr,
    output logic                mem_wen,
    output logic [XLEN/8-1:0]   mem_wmask,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_resp_valid,
    input  logic [XLEN-1:0]     mem_rdata
);

    localparam int IW = $clog2(XLEN / 8);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int c_tmo_last_i = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] c_tmo_last = c_tmo_last_i[CW-1:0];
    localparam logic [CW-1:0] c_cnt_one  = CW'(1);

    state_e            r_state;
    size_e             r_size;
    logic              r_uns;
    logic [IW-1:0]     r_idx;
    logic [CW-1:0]     r_cnt;

    size_e             w_size;
    logic              w_illegal;
    logic              w_misal;
    size_e             w_al_size;
    logic              w_al_uns;
    logic [IW-1:0]     w_al_idx;
    logic [XLEN/8-1:0] w_wmask;
    logic [XLEN-1:0]   w_wdata_sh;
    logic [XLEN-1:0]   w_rdata_ext;

    assign w_size    = size_e'(req_size);
    assign w_illegal = (XLEN == 32) && (w_size == SZ_D);
    assign w_misal   = is_misaligned(w_size, req_addr[2:0]);

    // One aligner serves both directions: live request fields while idle
    // (store mask/data), the registered request afterwards (load extraction).
    assign w_al_size = (r_state == ST_IDLE) ? w_size            : r_size;
    assign w_al_uns  = (r_state == ST_IDLE) ? req_unsigned      : r_uns;
    assign w_al_idx  = (r_state == ST_IDLE) ? req_addr[IW-1:0]  : r_idx;

    lsu_align #(
        .XLEN (XLEN),
        .IW   (IW)
    ) u_align (
        .size        (w_al_size),
        .is_unsigned (w_al_uns),
        .idx         (w_al_idx),
        .wdata       (req_wdata),
        .rdata       (mem_rdata),
        .wmask       (w_wmask),
        .wdata_sh    (w_wdata_sh),
        .rdata_ext   (w_rdata_ext)
    );

    assign req_ready     = (r_state == ST_IDLE);
    assign mem_req_valid = (r_state == ST_ISSUE);
    assign rsp_valid     = (r_state == ST_RESP);

    // Control FSM with registered memory-side and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_size    <= SZ_B;
            r_uns     <= 1'b0;
            r_idx     <= '0;
            r_cnt     <= '0;
            rsp_rdata <= '0;
            rsp_err   <= ERR_OK;
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wmask <= '0;
            mem_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_size    <= w_size;
                        r_uns     <= req_unsigned;
                        r_idx     <= req_addr[IW-1:0];
                        rsp_rdata <= '0;
                        if (w_illegal) begin
                            rsp_err <= ERR_SIZE;
                            r_state <= ST_RESP;
                        end else if (w_misal) begin
                            rsp_err <= ERR_MISALIGN;
                            r_state <= ST_RESP;
                        end else begin
                            rsp_err   <= ERR_OK;
                            mem_addr  <= {req_addr[AW-1:IW], {IW{1'b0}}};
                            mem_wen   <= req_wen;
                            mem_wmask <= req_wen ? w_wmask : '0;
                            mem_wdata <= w_wdata_sh;
                            r_state   <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    // A response seen while issuing is not ours yet; only the accept matters.
                    if (mem_req_ready) begin
                        r_cnt   <= '0;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_resp_valid) begin
                        rsp_rdata <= mem_wen ? '0 : w_rdata_ext;
                        rsp_err   <= ERR_OK;
                        r_state   <= ST_RESP;
                    end else if ((TIMEOUT != 0) && (r_cnt == c_tmo_last)) begin
                        rsp_rdata <= '0;
                        rsp_err   <= ERR_TIMEOUT;
                        r_state   <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lsu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_pipe
// Description : Directed self-checking bench for lsu_pipe (XLEN=64,
//               TIMEOUT=4) with a behavioural expectation model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_pipe;

    localparam int XLEN = 64;
    localparam int AW   = 64;
    localparam int TMO  = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_wen = 1'b0;
    logic [1:0]      req_size = 2'd0;
    logic            req_unsigned = 1'b0;
    logic [AW-1:0]   req_addr = '0;
    logic [XLEN-1:0] req_wdata = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b0;
    logic [XLEN-1:0] rsp_rdata;
    logic [1:0]      rsp_err;
    logic            mem_req_valid;
    logic            mem_req_ready = 1'b0;
    logic [AW-1:0]   mem_addr;
    logic            mem_wen;
    logic [7:0]      mem_wmask;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_resp_valid = 1'b0;
    logic [XLEN-1:0] mem_rdata = '0;

    lsu_pipe #(
        .XLEN    (XLEN),
        .AW      (AW),
        .TIMEOUT (TMO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_wen        (req_wen),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wmask      (mem_wmask),
        .mem_wdata      (mem_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Expected transaction outcome, computed from the access rules.
    logic        busy = 1'b0;
    logic        exp_issue = 1'b0;
    logic        exp_wen = 1'b0;
    logic [1:0]  exp_err = 2'd0;
    logic [63:0] exp_addr = '0;
    logic [7:0]  exp_wmask = '0;
    logic [63:0] exp_wdata = '0;
    logic [63:0] exp_rdata = '0;

    // DUT values captured at the memory accept and at the first response cycle.
    logic [63:0] cap_addr = '0;
    logic [7:0]  cap_wmask = '0;
    logic [63:0] cap_wdata = '0;
    logic [63:0] cap_rdata = '0;
    logic [1:0]  cap_err = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%h expected=0x%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_req_ready"},     64'(req_ready),     64'd1);
        check({pfx, "_rsp_valid"},     64'(rsp_valid),     64'd0);
        check({pfx, "_mem_req_valid"}, 64'(mem_req_valid), 64'd0);
        check({pfx, "_rsp_rdata"},     rsp_rdata,          64'd0);
        check({pfx, "_rsp_err"},       64'(rsp_err),       64'd0);
        check({pfx, "_mem_addr"},      mem_addr,           64'd0);
        check({pfx, "_mem_wdata"},     mem_wdata,          64'd0);
        check({pfx, "_mem_wmask"},     64'(mem_wmask),     64'd0);
        check({pfx, "_mem_wen"},       64'(mem_wen),       64'd0);
    endtask

    // Behavioural model: outcome of one access from size/address/data rules.
    task automatic model_set(input logic wen, input logic [1:0] size, input logic uns,
                             input logic [63:0] addr, input logic [63:0] wdata,
                             input logic [63:0] rdata, input int resp_dly);
        int          nb;
        int          idx;
        logic [63:0] keep;
        logic [63:0] v;
        nb        = 1 << size;
        idx       = int'(addr[2:0]);
        exp_wen   = wen;
        exp_addr  = addr & ~64'h7;
        exp_wmask = wen ? 8'(((64'd1 << nb) - 64'd1) << idx) : 8'h00;
        exp_wdata = wdata << (8 * idx);
        if ((addr % 64'(nb)) != 64'd0)
            exp_err = 2'd1;
        else if (resp_dly >= TMO)
            exp_err = 2'd2;
        else
            exp_err = 2'd0;
        exp_issue = (exp_err == 2'd0) || (exp_err == 2'd2);
        keep = (nb == 8) ? ~64'd0 : ((64'd1 << (8 * nb)) - 64'd1);
        v    = (rdata >> (8 * idx)) & keep;
        if (!uns && nb < 8 && v[8 * nb - 1])
            v = v | ~keep;
        exp_rdata = (exp_err == 2'd0 && !wen) ? v : 64'd0;
    endtask

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("req_ready", 64'(req_ready), 64'(!busy));
            if (!busy)
                check("rsp_valid_idle", 64'(rsp_valid), 64'd0);
            if (busy && !exp_issue)
                check("no_mem_req", 64'(mem_req_valid), 64'd0);
            if (mem_req_valid) begin
                check("mem_addr",  mem_addr,        exp_addr);
                check("mem_wen",   64'(mem_wen),    64'(exp_wen));
                check("mem_wmask", 64'(mem_wmask),  64'(exp_wmask));
                if (exp_wen)
                    check("mem_wdata", mem_wdata, exp_wdata);
            end
            if (rsp_valid) begin
                check("rsp_err",   64'(rsp_err), 64'(exp_err));
                check("rsp_rdata", rsp_rdata,    exp_rdata);
            end
        end
    end

    // One complete request: accept, memory handshake, response, consumer handshake.
    task automatic do_txn(input logic wen, input logic [1:0] size, input logic uns,
                          input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [63:0] rdata, input int ready_dly,
                          input int resp_dly, input int rsp_dly, input bit abort,
                          output int lat_acc, output int lat_macc);
        int n;
        int t_acc;
        int t_macc;
        int t_rsp;
        lat_acc  = 0;
        lat_macc = 0;
        t_macc   = 0;
        model_set(wen, size, uns, addr, wdata, rdata, resp_dly);
        req_valid    = 1'b1;
        req_wen      = wen;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        n = 0;
        while (!req_ready && n < 10) begin tick(); n++; end
        check("req_accept", 64'(req_ready), 64'd1);
        t_acc = cyc;
        busy  = 1'b1;
        tick();
        req_valid    = 1'b0;
        req_wen      = ~wen;
        req_size     = ~size;
        req_unsigned = ~uns;
        req_addr     = ~addr;
        req_wdata    = ~wdata;
        if (exp_issue) begin
            n = 0;
            while (!mem_req_valid && n < 10) begin tick(); n++; end
            check("mem_req_seen", 64'(mem_req_valid), 64'd1);
            mem_resp_valid = 1'b1;
            mem_rdata      = ~rdata;
            repeat (ready_dly) tick();
            mem_req_ready = 1'b1;
            t_macc    = cyc;
            cap_addr  = mem_addr;
            cap_wmask = mem_wmask;
            cap_wdata = mem_wdata;
            tick();
            mem_req_ready  = 1'b0;
            mem_resp_valid = 1'b0;
            mem_rdata      = rdata;
            if (abort) begin
                tick();
                #2;
                rst_n = 1'b0;
                #1;
                check_reset("abort");
                #2;
                rst_n = 1'b1;
                busy  = 1'b0;
                return;
            end
            if (resp_dly < TMO) begin
                repeat (resp_dly) tick();
                mem_resp_valid = 1'b1;
                tick();
                mem_resp_valid = 1'b0;
            end
        end
        n = 0;
        while (!rsp_valid && n < 20) begin tick(); n++; end
        check("rsp_seen", 64'(rsp_valid), 64'd1);
        t_rsp     = cyc;
        cap_err   = rsp_err;
        cap_rdata = rsp_rdata;
        if (rsp_dly > 0) begin
            req_valid = 1'b1;
            repeat (rsp_dly) tick();
            req_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        busy      = 1'b0;
        tick();
        rsp_ready = 1'b0;
        lat_acc  = t_rsp - t_acc;
        lat_macc = t_rsp - t_macc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int la;
        int lm;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("reset");
        #1;
        rst_n = 1'b1;
        tick();

        // Halfword store into the top lanes, zero-wait memory.
        do_txn(1'b1, 2'd1, 1'b0, 64'h8000_0006, 64'h0000_0000_0000_BEEF, 64'h0, 0, 0, 0, 1'b0, la, lm);
        check("st_h_addr",  cap_addr,          64'h8000_0000);
        check("st_h_wmask", 64'(cap_wmask),    64'hC0);
        check("st_h_wdata", cap_wdata >> 48,   64'hBEEF);
        check("st_h_err",   64'(cap_err),      64'd0);
        check("st_h_rdata", cap_rdata,         64'd0);
        check("st_h_lat",   64'(la),           64'd3);

        // Byte load, signed then unsigned.
        do_txn(1'b0, 2'd0, 1'b0, 64'h8000_0003, 64'h0, 64'h0000_0000_80FF_0000, 0, 0, 0, 1'b0, la, lm);
        check("ld_b_s_rdata", cap_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        check("ld_b_s_lat",   64'(la),   64'd3);
        do_txn(1'b0, 2'd0, 1'b1, 64'h8000_0003, 64'h0, 64'h0000_0000_80FF_0000, 0, 0, 0, 1'b0, la, lm);
        check("ld_b_u_rdata", cap_rdata, 64'h80);

        // Misaligned word load: error without a memory access.
        do_txn(1'b0, 2'd2, 1'b0, 64'h8000_0002, 64'h0, 64'h0, 0, 0, 0, 1'b0, la, lm);
        check("misal_err", 64'(cap_err), 64'd1);
        check("misal_lat", 64'(la),      64'd1);

        // Memory never answers: timeout four cycles after entering WAIT.
        do_txn(1'b0, 2'd3, 1'b0, 64'h8000_0010, 64'h0, 64'hDEAD_BEEF_0BAD_F00D, 0, 10, 0, 1'b0, la, lm);
        check("tmo_err",   64'(cap_err), 64'd2);
        check("tmo_rdata", cap_rdata,    64'd0);
        check("tmo_lat",   64'(lm),      64'd5);

        // Response lands exactly on the timeout cycle: response wins.
        do_txn(1'b0, 2'd3, 1'b0, 64'h8000_0018, 64'h0, 64'h1122_3344_5566_7788, 0, 3, 0, 1'b0, la, lm);
        check("tmo_edge_err",   64'(cap_err), 64'd0);
        check("tmo_edge_rdata", cap_rdata,    64'h1122_3344_5566_7788);
        check("tmo_edge_lat",   64'(lm),      64'd5);

        // Stalled memory accept and stalled consumer with a competing request.
        do_txn(1'b1, 2'd2, 1'b0, 64'h8000_0104, 64'h0000_0000_CAFE_BABE, 64'h0, 5, 1, 3, 1'b0, la, lm);
        check("stall_addr",  cap_addr,       64'h8000_0100);
        check("stall_wmask", 64'(cap_wmask), 64'hF0);
        check("stall_wdata", cap_wdata,      64'hCAFE_BABE_0000_0000);
        check("stall_err",   64'(cap_err),   64'd0);

        // Further extension cases.
        do_txn(1'b0, 2'd1, 1'b0, 64'h8000_000A, 64'h0, 64'h0000_0000_8001_0000, 0, 2, 1, 1'b0, la, lm);
        check("ld_h_s_rdata", cap_rdata, 64'hFFFF_FFFF_FFFF_8001);
        do_txn(1'b0, 2'd2, 1'b1, 64'h8000_0004, 64'h0, 64'hF000_0000_0000_0000, 1, 0, 0, 1'b0, la, lm);
        check("ld_w_u_rdata", cap_rdata, 64'h0000_0000_F000_0000);
        do_txn(1'b0, 2'd2, 1'b0, 64'h8000_0004, 64'h0, 64'hF000_0000_0000_0000, 0, 1, 0, 1'b0, la, lm);
        check("ld_w_s_rdata", cap_rdata, 64'hFFFF_FFFF_F000_0000);
        do_txn(1'b1, 2'd3, 1'b0, 64'h8000_0004, 64'h1234, 64'h0, 0, 0, 0, 1'b0, la, lm);
        check("st_d_misal_err", 64'(cap_err), 64'd1);
        do_txn(1'b1, 2'd0, 1'b0, 64'h8000_0005, 64'h0000_0000_0000_00A5, 64'h0, 0, 0, 0, 1'b0, la, lm);
        check("st_b_wmask", 64'(cap_wmask), 64'h20);
        check("st_b_wdata", cap_wdata,      64'h0000_A500_0000_0000);

        // Reset while waiting on memory, then a normal access.
        do_txn(1'b0, 2'd2, 1'b0, 64'h8000_0020, 64'h0, 64'h0, 0, 10, 0, 1'b1, la, lm);
        tick();
        do_txn(1'b0, 2'd3, 1'b0, 64'h8000_0028, 64'h0, 64'h0102_0304_0506_0708, 0, 1, 0, 1'b0, la, lm);
        check("post_rst_err",   64'(cap_err), 64'd0);
        check("post_rst_rdata", cap_rdata,    64'h0102_0304_0506_0708);

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
